seg7_value_display: RTL and testbench

SEG7_VALUE_DISPLAY -- requirements
Module: seg7_value_display

---
 rtl/seg7_value_display_pkg.sv | 39 +++
 rtl/seg7_value_display_bin2bcd8.sv | 68 ++++++
 rtl/seg7_value_display.sv | 74 +++++++
 tb/tb_seg7_value_display.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg7_value_display_pkg.sv
// Shared constants for the value display: segment codes (active-low g..a)
// and the binary-to-BCD converter state encoding.
package seg7_value_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_value_display_bin2bcd8.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3, 8 steps).
// bcd = {hundreds[1:0], tens[3:0], ones[3:0]}, final while done is high.
module bin2bcd8
    import seg7_value_display_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [9:0] bcd
);

    conv_state_t state, state_nxt;
    logic [17:0] sr;      // {hundreds, tens, ones, remaining binary}
    logic [17:0] sr_step;
    logic [2:0]  cnt;

    always_comb begin
        sr_step = sr;
        if (sr_step[11:8] >= 4'd5)  sr_step[11:8]  = sr_step[11:8] + 4'd3;
        if (sr_step[15:12] >= 4'd5) sr_step[15:12] = sr_step[15:12] + 4'd3;
        sr_step = sr_step << 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (start) begin
                    sr  <= {10'd0, bin};
                    cnt <= '0;
                end
                ST_SHIFT: begin
                    sr  <= sr_step;
                    cnt <= cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: if (cnt == 3'd7) state_nxt = ST_DONE;
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bcd = sr[17:8];

endmodule

// File: rtl/seg7_value_display.sv
// Shows value8 (0..255) in decimal on a 4-digit multiplexed 7-segment display;
// conversion runs whenever value8 differs from the last converted value.
module seg7_value_display
    import seg7_value_display_pkg::*;
#(
    parameter int DIV_BITS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value8,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       conv_busy
);

    logic [7:0]          last_value;
    logic [9:0]          disp_bcd;
    logic [DIV_BITS-1:0] scan_cnt;
    logic [1:0]          sel;
    logic                start, busy, done;
    logic [9:0]          bcd;
    logic [6:0]          digit_seg;
    logic [1:0]          hundreds;
    logic [3:0]          tens, ones;

    assign start = (value8 != last_value) && !busy;

    bin2bcd8 u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (value8),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    assign hundreds = disp_bcd[9:8];
    assign tens     = disp_bcd[7:4];
    assign ones     = disp_bcd[3:0];
    assign sel      = scan_cnt[DIV_BITS-1 -: 2];

    // Leading-zero blanking: tens only lit once the value reaches 10.
    always_comb begin
        digit_seg = SEG_BLANK;
        case (sel)
            2'd0: digit_seg = seg_code(ones);
            2'd1: if (hundreds != 2'd0 || tens != 4'd0) digit_seg = seg_code(tens);
            2'd2: if (hundreds != 2'd0) digit_seg = seg_code({2'b00, hundreds});
            default: digit_seg = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_value <= '0;
            disp_bcd   <= '0;
            scan_cnt   <= '0;
            an         <= 4'b1111;
            seg        <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            if (start) last_value <= value8;
            if (done)  disp_bcd   <= bcd;
            an  <= ~(4'b0001 << sel);
            seg <= digit_seg;
        end
    end

    assign dp        = 1'b1;
    assign conv_busy = busy;

endmodule

// File: tb/tb_seg7_value_display.sv
// Randomized self-checking bench for seg7_value_display (DIV_BITS=4) against
// a cycle-level decimal model of conversion latency and digit scanning.
module tb_seg7_value_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] value8;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       conv_busy;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_value_display #(.DIV_BITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .value8    (value8),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .conv_busy (conv_busy)
    );

    always #5 clk = ~clk;

    logic [6:0] codes [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

    // model state
    int         k;        // edges since reset release
    int         m_left;   // edges until the pending value is displayed
    int         m_disp;
    int         m_pend;
    int         m_last;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_code(input int d, input int v);
        case (d)
            0:       return codes[v % 10];
            1:       return (v < 10)  ? 7'h7f : codes[(v / 10) % 10];
            2:       return (v < 100) ? 7'h7f : codes[v / 100];
            default: return 7'h7f;
        endcase
    endfunction

    task automatic model_reset();
        k = 0; m_left = 0; m_disp = 0; m_pend = 0; m_last = 0;
        exp_an = 4'b1111; exp_seg = 7'h7f;
    endtask

    task automatic check_outputs();
        chk("an",   {28'd0, an},  {28'd0, exp_an});
        chk("seg",  {25'd0, seg}, {25'd0, exp_seg});
        chk("busy", {31'd0, conv_busy}, (m_left > 0) ? 32'd1 : 32'd0);
        chk("dp",   {31'd0, dp},  32'd1);
    endtask

    task automatic step();
        int d;
        @(posedge clk);
        if (reset) model_reset();
        else begin
            k++;
            d = ((k - 1) >> 2) & 3;
            exp_an  = ~(4'b0001 << d);
            exp_seg = digit_code(d, m_disp);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_disp = m_pend;
            end else if (int'(value8) != m_last) begin
                m_last = value8; m_pend = value8; m_left = 9;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1 check_outputs();
    endtask

    initial begin
        reset  = 1'b1;
        value8 = 8'd0;
        model_reset();
        #2 check_outputs();
        @(negedge clk);
        reset = 1'b0;
        repeat (16) step();

        value8 = 8'd255;
        repeat (24) step();

        value8 = 8'd7;
        repeat (24) step();

        value8 = 8'd100;
        repeat (3) step();
        value8 = 8'd42;
        repeat (36) step();

        value8 = 8'd200;
        repeat (4) step();
        do_reset();
        repeat (2) step();
        reset = 1'b0;
        repeat (28) step();

        for (int i = 0; i < 40; i++) begin
            value8 = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 14)) step();
        end

        for (int v = 0; v < 256; v++) begin
            int t;
            value8 = 8'(v);
            step();
            t = 0;
            while (conv_busy && t < 20) begin
                step();
                t++;
            end
            chk("sweep_busy_timeout", (t < 20) ? 32'd1 : 32'd0, 32'd1);
            repeat (16) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
